// File: rtl/div_scheduler.sv
// div_scheduler
//
// Shared signed-divider scheduler. Requesters are arbitrated round-robin onto
// one radix-2 restoring divider. The divider works on operand magnitudes and
// fixes the signs afterwards. Each result goes back tagged with the id of the
// requester that issued it. Results match Verilog signed '/' and '%':
// truncation toward zero, and the remainder takes the sign of the dividend.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a request; grants one requester per visit
//   DIV    | one restoring step per cycle, WIDTH steps in total
//   FIX    | sign correction, results registered
//   RESP   | result presented until rsp_valid && rsp_ready
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   req_valid        per-requester request valid
//   req_ready        per-requester accept (one-hot or zero, only in IDLE)
//   req_dividend     packed dividends, requester i at [i*WIDTH +: WIDTH]
//   req_divisor      packed divisors, same packing
//   rsp_valid        result valid
//   rsp_ready        consumer accept
//   rsp_id           owner of the result
//   rsp_quotient     signed quotient
//   rsp_remainder    signed remainder
//   rsp_div_by_zero  divisor was zero
//   busy             scheduler not in IDLE
module div_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_dividend,
    input  logic [NREQ*WIDTH-1:0]  req_divisor,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_quotient,
    output logic [WIDTH-1:0]       rsp_remainder,
    output logic                   rsp_div_by_zero,
    output logic                   busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand;
    logic             grant_any;
    logic [NREQ-1:0]  grant_oh;
    logic             hs;

    logic [WIDTH-1:0] sel_dvd, sel_dvs, mag_dvd, mag_dvs;
    logic             sel_dvs_zero;

    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, becomes the quotient magnitude
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic             neg_dvd_q, neg_dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             step_ge;

    // Round-robin search, starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        grant_oh  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        grant_oh[grant_id] = 1'b1;
    end

    assign sel_dvd      = req_dividend[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_dvs      = req_divisor[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_dvs_zero = (sel_dvs == '0);
    // The most negative value negates to itself; read as unsigned it is
    // the correct magnitude 2^(WIDTH-1).
    assign mag_dvd      = sel_dvd[WIDTH-1] ? -sel_dvd : sel_dvd;
    assign mag_dvs      = sel_dvs[WIDTH-1] ? -sel_dvs : sel_dvs;

    // The partial remainder is always smaller than the divisor magnitude,
    // so WIDTH bits hold it. One extra bit is needed only for the shifted
    // value before the compare.
    assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign step_ge = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        hs        = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // Gating with rst keeps req_ready low while reset is held.
                hs   = grant_any && rst;
                if (hs) begin
                    req_ready = grant_oh;
                    state_nxt = sel_dvs_zero ? S_RESP : S_DIV;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr             <= IDW'(NREQ - 1);
            dvd_q           <= '0;
            dvs_q           <= '0;
            rem_q           <= '0;
            neg_dvd_q       <= 1'b0;
            neg_dvs_q       <= 1'b0;
            cnt_q           <= '0;
            rsp_id          <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        ptr       <= grant_id;
                        rsp_id    <= grant_id;
                        dvd_q     <= mag_dvd;
                        dvs_q     <= mag_dvs;
                        neg_dvd_q <= sel_dvd[WIDTH-1];
                        neg_dvs_q <= sel_dvs[WIDTH-1];
                        rem_q     <= '0;
                        cnt_q     <= CW'(WIDTH - 1);
                        // Divide by zero skips the divider entirely.
                        if (sel_dvs_zero) begin
                            rsp_quotient    <= '1;
                            rsp_remainder   <= sel_dvd;
                            rsp_div_by_zero <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= step_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], step_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    rsp_quotient    <= (neg_dvd_q ^ neg_dvs_q) ? -dvd_q : dvd_q;
                    rsp_remainder   <= neg_dvd_q ? -rem_q : rem_q;
                    rsp_div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
